// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, PC-select encodings used by both the
// branch unit and the PC/IR unit, and the fetch state enum.
package cpu_pkg;

  localparam int WORD_W = 32;

  // PC-select field of the control word.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_PLUS4 = 2'd1,
    PC_JUMP  = 2'd2,
    PC_IN    = 2'd3
  } pc_sel_e;

  // Instruction fetch sequencing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: hold, +4, word-relative jump, absolute load.
// Optional build macro PC_ALIGN_CHECK_EN: a misaligned absolute target is
// rejected (PC held, misalign flagged) instead of being truncated to a word.
module pc_next
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic [WORD_W-1:0] k,
  input  logic [WORD_W-1:0] pc_in,
  output logic [WORD_W-1:0] next_pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              misalign
);

  assign pc_plus4 = pc + 32'd4;

  // Next-PC mux; all arithmetic wraps modulo 2^32.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    next_pc  = pc;
    misalign = 1'b0;
    case (pc_sel_e'(pc_sel))
      PC_HOLD:  next_pc = pc;
      PC_PLUS4: next_pc = pc_plus4;
      PC_JUMP:  next_pc = pc + (k << 2);
      PC_IN: begin
`ifdef PC_ALIGN_CHECK_EN
        if (pc_in[1:0] != 2'b00) misalign = 1'b1;
        else                     next_pc  = pc_in;
`else
        next_pc = {pc_in[WORD_W-1:2], 2'b00};
`endif
      end
      default:  next_pc = pc;
    endcase
  end

`ifndef PC_ALIGN_CHECK_EN
  // Byte-offset bits of the target are discarded in this build.
  logic unused_pc_in_lsbs;
  assign unused_pc_in_lsbs = ^pc_in[1:0];
`endif

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter and instruction register. Holds the PC, updates it from the
// PC-select field while idle, fetches the word at PC over a req/ack handshake
// with a bounded wait, and presents the latched instruction on IR.
// Optional build macro PC_ALIGN_CHECK_EN enables align_err on misaligned IN.
module pc_ir_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                WAIT_LIMIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        pc_sel,
  input  logic [WORD_W-1:0] k,
  input  logic [WORD_W-1:0] pc_in,
  input  logic              ir_load,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] IR,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic              align_err
);

  // Counter value on the edge where the wait reaches WAIT_LIMIT.
  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  fetch_state_e      state;
  logic [7:0]        wait_cnt;
  logic [WORD_W-1:0] next_pc;
  logic              misalign;

  pc_next u_pc_next (
    .pc       (PC),
    .pc_sel   (pc_sel),
    .k        (k),
    .pc_in    (pc_in),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4),
    .misalign (misalign)
  );

  assign busy = (state != ST_IDLE);

  // Fetch FSM, wait counter, PC and IR registers; pulses default low each cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      PC        <= RESET_PC;
      IR        <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      align_err <= 1'b0;
    end else begin
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      align_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          PC        <= next_pc;
          align_err <= misalign;
          if (ir_load) begin
            mem_addr <= PC;  // fetch uses the PC from before this edge's update
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            IR       <= mem_data;
            mem_req  <= 1'b0;
            ir_valid <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed steps from the test plan, then
// randomized traffic, all compared every cycle with a behavioural model.
module tb_pc_ir_unit;

  localparam int          WAIT_LIMIT = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pc_sel;
  logic [31:0] k, pc_in, mem_data;
  logic        ir_load, mem_ack;
  logic [31:0] mem_addr, PC, pc_plus4, IR;
  logic        mem_req, ir_valid, busy, fetch_err, align_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_ir, m_addr;
  logic        m_req, m_valid, m_ferr, m_aerr;
  bit          m_fetching, m_done_cycle;
  int          m_waited;

  pc_ir_unit #(.RESET_PC(RESET_PC), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clock(clock), .reset(reset), .pc_sel(pc_sel), .k(k), .pc_in(pc_in),
    .ir_load(ir_load), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_data(mem_data), .mem_ack(mem_ack), .PC(PC), .pc_plus4(pc_plus4),
    .IR(IR), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err),
    .align_err(align_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("PC",        PC,               m_pc);
    check("pc_plus4",  pc_plus4,         m_pc + 32'd4);
    check("IR",        IR,               m_ir);
    check("mem_addr",  mem_addr,         m_addr);
    check("mem_req",   32'(mem_req),     32'(m_req));
    check("ir_valid",  32'(ir_valid),    32'(m_valid));
    check("busy",      32'(busy),        32'(m_fetching || m_done_cycle));
    check("fetch_err", 32'(fetch_err),   32'(m_ferr));
    check("align_err", 32'(align_err),   32'(m_aerr));
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input logic rst, input logic [1:0] sel, input logic [31:0] kk,
                            input logic [31:0] pin, input logic ld, input logic ack,
                            input logic [31:0] data);
    if (rst) begin
      m_pc = RESET_PC; m_ir = 0; m_addr = 0; m_req = 0;
      m_valid = 0; m_ferr = 0; m_aerr = 0;
      m_fetching = 0; m_done_cycle = 0; m_waited = 0;
      return;
    end
    m_valid = 0; m_ferr = 0; m_aerr = 0;
    if (m_done_cycle) begin
      m_done_cycle = 0;
    end else if (m_fetching) begin
      if (ack) begin
        m_ir = data; m_req = 0; m_valid = 1;
        m_fetching = 0; m_done_cycle = 1;
      end else begin
        m_waited++;
        if (m_waited == WAIT_LIMIT) begin
          m_req = 0; m_ferr = 1; m_fetching = 0;
        end
      end
    end else begin
      if (ld) begin
        m_addr = m_pc; m_req = 1; m_fetching = 1; m_waited = 0;
      end
      case (sel)
        2'd1: m_pc = m_pc + 4;
        2'd2: m_pc = m_pc + kk * 4;
        2'd3: begin
`ifdef PC_ALIGN_CHECK_EN
          if (pin % 4 != 0) m_aerr = 1;
          else              m_pc = pin;
`else
          m_pc = pin - (pin % 4);
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic rst, input logic [1:0] sel, input logic [31:0] kk,
                       input logic [31:0] pin, input logic ld, input logic ack,
                       input logic [31:0] data);
    reset = rst; pc_sel = sel; k = kk; pc_in = pin;
    ir_load = ld; mem_ack = ack; mem_data = data;
    model_step(rst, sel, kk, pin, ld, ack, data);
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] pc_before;
    reset = 1; pc_sel = 0; k = 0; pc_in = 0; ir_load = 0; mem_ack = 0; mem_data = 0;

    // Reset state.
    cycle(1, 2'd0, 0, 0, 0, 0, 0);
    cycle(1, 2'd0, 0, 0, 0, 0, 0);
    check("reset_pc", PC, 32'h0);
    check("reset_ir", IR, 32'h0);

    // Three PLUS4 cycles from reset.
    repeat (3) cycle(0, 2'd1, 0, 0, 0, 0, 0);
    check("plus4x3_pc", PC, 32'h0000_000C);
    check("plus4x3_link", pc_plus4, 32'h0000_0010);

    // Negative jump and PC wraparound.
    cycle(0, 2'd3, 0, 32'h0000_0100, 0, 0, 0);
    cycle(0, 2'd2, 32'hFFFF_FFFE, 0, 0, 0, 0);
    check("jump_neg", PC, 32'h0000_00F8);
    cycle(0, 2'd3, 0, 32'hFFFF_FFFC, 0, 0, 0);
    cycle(0, 2'd1, 0, 0, 0, 0, 0);
    check("plus4_wrap", PC, 32'h0000_0000);

    // Fetch with simultaneous PLUS4, JUMP ignored during FETCH, ack on 3rd cycle.
    cycle(0, 2'd3, 0, 32'h0000_0040, 0, 0, 0);
    cycle(0, 2'd1, 0, 0, 1, 0, 0);
    check("fetch_addr", mem_addr, 32'h0000_0040);
    check("fetch_pc", PC, 32'h0000_0044);
    cycle(0, 2'd2, 32'd5, 0, 0, 0, 0);
    cycle(0, 2'd2, 32'd5, 0, 0, 0, 0);
    cycle(0, 2'd2, 32'd5, 0, 0, 1, 32'hB500_0002);
    check("fetch_ir", IR, 32'hB500_0002);
    check("fetch_valid", 32'(ir_valid), 32'd1);
    check("fetch_pc_frozen", PC, 32'h0000_0044);
    cycle(0, 2'd0, 0, 0, 1, 0, 0);
    check("valid_pulse_end", 32'(ir_valid), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);

    // Timeout: fetch_err WAIT_LIMIT cycles after mem_req rises.
    cycle(0, 2'd0, 0, 0, 1, 0, 0);
    repeat (WAIT_LIMIT - 1) begin
      cycle(0, 2'd0, 0, 0, 0, 0, 0);
      check("no_early_timeout", 32'(fetch_err), 32'd0);
    end
    cycle(0, 2'd0, 0, 0, 0, 0, 0);
    check("timeout_err", 32'(fetch_err), 32'd1);
    check("timeout_req", 32'(mem_req), 32'd0);
    check("timeout_ir", IR, 32'hB500_0002);
    cycle(0, 2'd0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("stray_ack_ir", IR, 32'hB500_0002);
    check("stray_ack_busy", 32'(busy), 32'd0);

    // Misaligned absolute target.
    pc_before = m_pc;
    cycle(0, 2'd3, 0, 32'h0000_1002, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc_held", PC, pc_before);
    check("align_err", 32'(align_err), 32'd1);
    cycle(0, 2'd0, 0, 0, 0, 0, 0);
    check("align_err_pulse", 32'(align_err), 32'd0);
`else
    check("align_truncate", PC, 32'h0000_1000);
    check("align_err_tied", 32'(align_err), 32'd0);
`endif

    // Reset in the middle of a fetch; late ack ignored.
    cycle(0, 2'd3, 0, 32'h0000_0200, 1, 0, 0);
    cycle(0, 2'd0, 0, 0, 0, 0, 0);
    cycle(1, 2'd0, 0, 0, 0, 0, 0);
    check("midreset_req", 32'(mem_req), 32'd0);
    check("midreset_pc", PC, RESET_PC);
    check("midreset_ir", IR, 32'h0);
    cycle(0, 2'd0, 0, 0, 0, 1, 32'h1234_5678);
    check("late_ack_ir", IR, 32'h0);
    check("late_ack_valid", 32'(ir_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_ld, r_ack;
      logic [1:0]  r_sel;
      logic [31:0] r_k, r_pin, r_data;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_sel  = 2'($urandom_range(0, 3));
      r_k    = $urandom;
      r_pin  = $urandom;
      r_ld   = ($urandom_range(0, 1) == 1);
      r_ack  = ($urandom_range(0, 9) < 3);
      r_data = $urandom;
      cycle(r_rst, r_sel, r_k, r_pin, r_ld, r_ack, r_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Program-counter and instruction-register unit feeding the control unit. It holds the PC and updates it from the control word's PC-select field (hold, +4, relative jump, register load), fetches the instruction at PC through a variable-latency memory handshake, and presents the latched instruction to the control unit on `IR`. It is the supplier end of the control unit's `IR` input and the consumer of its branch unit's PC-select output.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `WAIT_LIMIT`, 15, maximum cycles in FETCH without `mem_ack` before abandoning the fetch (1..255).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc_sel`  in  2  0=HOLD, 1=PLUS4, 2=JUMP, 3=IN.
- `k`  in  32  signed word offset for JUMP, already sign-extended by the control unit.
- `pc_in`  in  32  absolute target for IN (BR).
- `ir_load`  in  1  request an instruction fetch at the current PC.
- `mem_addr`  out  32  fetch address, registered.
- `mem_req`  out  1  fetch request, registered.
- `mem_data`  in  32  instruction word, valid with `mem_ack`.
- `mem_ack`  in  1  memory completion.
- `PC`  out  32  current program counter.
- `pc_plus4`  out  32  PC+4, combinational, used as the BL link value.
- `IR`  out  32  latched instruction.
- `ir_valid`  out  1  one-cycle pulse after `IR` updates.
- `busy`  out  1  high whenever state != IDLE.
- `fetch_err`  out  1  one-cycle pulse when a fetch times out.
- `align_err`  out  1  one-cycle pulse when an IN target is misaligned.

## Operation
- States: IDLE, FETCH, DONE.
- IDLE:
  - `ir_load`=1 latches `mem_addr` to the current PC (before that cycle's PC update) and sets `mem_req`; next state is FETCH.
  - PC update, IDLE only:
    - HOLD: PC unchanged.
    - PLUS4: PC ← PC+4.
    - JUMP: PC ← PC + (k<<2).
    - IN: PC ← pc_in.
  - All PC arithmetic is modulo 2^32 and wraps silently.
  - `ir_load` together with a non-HOLD `pc_sel` in the same cycle is legal: the fetch uses the old PC and the PC updates on the same edge.
- FETCH:
  - `mem_req` stays high and `mem_addr` stays stable.
  - The wait counter increments each cycle without `mem_ack`.
  - `mem_ack`=1: IR ← `mem_data`, `mem_req` ← 0, next state DONE.
  - Counter reaches `WAIT_LIMIT` without ack: `mem_req` ← 0, IR unchanged, `fetch_err` pulses, next state IDLE.
  - `pc_sel` and `ir_load` are ignored; the PC is frozen.
- DONE: `ir_valid`=1 for exactly this cycle; next state IDLE unconditionally; `ir_load` is ignored.
- `mem_ack` outside FETCH is ignored.
- Reset values: PC=`RESET_PC`, IR=0, `mem_req`=0, `mem_addr`=0, `ir_valid`=0, `fetch_err`=0, `align_err`=0, state=IDLE, counter=0.
- Reset mid-fetch drops `mem_req` on the next edge; a late `mem_ack` is then ignored.

## Timing
- `ir_load` at edge T:
  - `mem_req` is high after T.
  - `mem_ack` sampled at T+1 loads IR at T+1.
  - `ir_valid` is high during cycle T+1..T+2.
  - `busy` falls after T+2.
- Minimum fetch-to-valid latency: 2 cycles. The earliest next `ir_load` is accepted at T+3.
- PC updates take effect on the edge where IDLE and `pc_sel` are sampled.
- A fetch timeout occurs `WAIT_LIMIT` cycles after `mem_req` rises; `fetch_err` and the deassertion of `mem_req` happen on the same edge.

## Configuration
- `PC_ALIGN_CHECK_EN` defined: on IN with `pc_in[1:0]`≠0, PC is unchanged and `align_err` pulses for one cycle.
- `PC_ALIGN_CHECK_EN` undefined: IN loads {`pc_in[31:2]`,2'b00} and `align_err` is tied 0.
- JUMP and PLUS4 cannot misalign from an aligned PC; they are unchecked in both builds.

## Structure
- Shared package `cpu_pkg`:
  - `pc_sel` encodings (PC_HOLD, PC_PLUS4, PC_JUMP, PC_IN), shared with the branch unit.
  - Fetch state enum.
  - Word width constant (32).
- One sub-module, `pc_next`: combinational next-PC mux and adders. It outputs the next PC and the misalignment flag.
- The FSM, wait counter and IR register stay in `pc_ir_unit`.

## Test plan
- Reset, then `pc_sel`=PLUS4 for 3 IDLE cycles -> PC=0x0C, `pc_plus4`=0x10.
- PC=0x100, JUMP with k=-2 (0xFFFF_FFFE) -> PC=0x0F8. PC=0xFFFF_FFFC, PLUS4 -> PC=0.
- PC=0x40, `ir_load`+PLUS4 in the same cycle, ack after 3 cycles with `mem_data`=0xB500_0002 -> `mem_addr`=0x40, PC=0x44, IR=0xB500_0002, one `ir_valid` pulse; `pc_sel`=JUMP during FETCH leaves PC at 0x44.
- `WAIT_LIMIT`=4, `ir_load` with no ack -> `fetch_err` pulses 4 cycles after `mem_req` rises, IR unchanged, state returns to IDLE; a later stray `mem_ack` is ignored.
- With `PC_ALIGN_CHECK_EN`: IN with `pc_in`=0x1002 -> PC unchanged, `align_err`=1 for one cycle. Without it: PC=0x1000.
- Reset asserted mid-FETCH -> next edge `mem_req`=0, PC=`RESET_PC`, IR=0; a `mem_ack` in the following cycle has no effect.
